nibble_serial_subtractor: RTL
=============================

# nibble_serial_subtractor

Multi-cycle WIDTH-bit subtractor (a − b − borrow_in) that processes one 4-bit nibble per clock through a single carry-lookahead slice, chaining the borrow between cycles. It sits beside the combinational 4-bit CLA adder path as the area-cheap subtract/compare unit. Operands enter and results leave over valid/ready handshakes.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, ≥ 4
- NIBBLES, WIDTH/4, derived; number of RUN cycles
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand request
- in_ready  out  1  high only in IDLE
- a  in  WIDTH  minuend
- b  in  WIDTH  subtrahend
- borrow_in  in  1  borrow into LSB
- out_valid  out  1  result available (DONE)
- out_ready  in  1  consumer accepts result
- d  out  WIDTH  difference, registered
- borrow_out  out  1  borrow out of MSB (1 ⇔ unsigned a < b + borrow_in)
- zero  out  1  d == 0
- ovf  out  1  signed overflow (only with SUB_OVF_FLAG_EN)

## Operation
- FSM: IDLE → RUN → DONE → IDLE; reset state IDLE.
- IDLE: in_ready=1. On in_valid at an edge: latch a, b; carry register c ← ~borrow_in; nibble index idx ← 0; go RUN.
- RUN: each edge computes nibble idx: {c', s} = a[idx] + ~b[idx] + c; d[idx] ← s; c ← c'; idx++. After idx = NIBBLES−1: borrow_out ← ~c', zero ← (full d == 0), go DONE.
- DONE: out_valid=1; d, borrow_out, zero, ovf held stable. On out_ready at an edge → IDLE.
- in_valid outside IDLE is ignored (no queuing, no overlap).
- Arithmetic modulo 2^WIDTH; d never wider than WIDTH.
- Reset mid-operation: current operation discarded, no result emitted.

## Timing
- Accept at edge E; nibbles 0..NIBBLES−1 processed at edges E+1..E+NIBBLES; out_valid high after edge E+NIBBLES (WIDTH=16: 4 cycles).
- Result handshake at edge F; in_ready high after F; next accept earliest at F+1. Minimum period NIBBLES+2 cycles.
- out_ready held low: out_valid stays 1 and outputs frozen indefinitely.
- Reset values: in_ready=1, out_valid=0, d=0, borrow_out=0, zero=0, ovf=0, idx=0.
- All outputs registered or decoded from the state register only; no combinational in→out paths.

## Configuration
- SUB_OVF_FLAG_EN defined: ovf port present; on final nibble ovf ← carry into bit 3 of top slice XOR carry out of it; valid with out_valid, held in DONE.
- Not defined: ovf port and its logic absent; all other behaviour identical.

## Structure
- Shared package: state encoding typedef (IDLE, RUN, DONE), NIBBLE_W = 4 constant, idx width function ($clog2(NIBBLES), min 1).
- One sub-module: sub_lookahead_4bit, combinational 4-bit a + ~b + c_in with generate/propagate lookahead; outputs s[3:0], c_out, c3 (carry into bit 3, for ovf).

## Test plan
- a=0x1234, b=0x0234, borrow_in=0 → d=0x1000, borrow_out=0, zero=0; out_valid rises exactly 4 edges after accept.
- a=0x0000, b=0x0001, borrow_in=0 → d=0xFFFF, borrow_out=1, zero=0 (ovf=0 when enabled).
- a=0x5A5A, b=0x5A59, borrow_in=1 → d=0x0000, zero=1, borrow_out=0.
- With SUB_OVF_FLAG_EN: a=0x8000, b=0x0001 → d=0x7FFF, ovf=1, borrow_out=0; a=0x7FFF, b=0xFFFF → d=0x8000, ovf=1, borrow_out=1.
- Backpressure: out_ready low 3 cycles after out_valid → d/flags stable, in_ready=0, a new in_valid pulse is ignored; after out_ready, next op accepted and correct.
- Assert rst while RUN at idx=2 → out_valid=0, in_ready=1 immediately; following op a=0x0010, b=0x0001 → d=0x000F.

Source files
------------

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: state encoding,
// slice width and the nibble index width helper.
package nibble_serial_subtractor_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the nibble index; never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_subtractor_lookahead.sv
// sub_lookahead_4bit: combinational 4-bit a + ~b + c_in slice with
// generate/propagate carry lookahead. c3 is the carry into bit 3, which the
// top uses to form the signed overflow flag on the most significant nibble.
module sub_lookahead_4bit
    import nibble_serial_subtractor_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] s,
    output logic                c_out,
    output logic                c3
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    // Per-bit generate/propagate against the inverted subtrahend.
    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_gp
        assign g[gi] = a[gi] & ~b[gi];
        assign p[gi] = a[gi] ^ ~b[gi];
    end

    // Flattened lookahead carries: each depends only on g, p and c_in.
    always_comb begin
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_in);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);
    end

    assign s     = p ^ c[NIBBLE_W-1:0];
    assign c_out = c[4];
    assign c3    = c[3];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: WIDTH-bit a - b - borrow_in computed one nibble
// per clock through a single lookahead slice, with the carry (inverted
// borrow) chained between cycles. Valid/ready handshakes on both sides.
// Optional feature macro: SUB_OVF_FLAG_EN adds the signed overflow port ovf.
module nibble_serial_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow_out,
    output logic             zero
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_width(NIBBLES);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, b_q, d_q, d_d;
    logic                 c_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 borrow_q, zero_q;
    logic                 last_nib;

    logic [NIBBLE_W-1:0]  a_nib [NIBBLES];
    logic [NIBBLE_W-1:0]  b_nib [NIBBLES];
    logic [NIBBLE_W-1:0]  sum_nib;
    logic                 c_out;

    // Split the latched operands into nibbles so the slice input is a mux.
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign a_nib[gi] = a_q[gi*NIBBLE_W +: NIBBLE_W];
        assign b_nib[gi] = b_q[gi*NIBBLE_W +: NIBBLE_W];
    end

    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

`ifdef SUB_OVF_FLAG_EN
    logic c3;
    logic ovf_q;

    sub_lookahead_4bit u_slice (
        .a     (a_nib[idx_q]),
        .b     (b_nib[idx_q]),
        .c_in  (c_q),
        .s     (sum_nib),
        .c_out (c_out),
        .c3    (c3)
    );
`else
    sub_lookahead_4bit u_slice (
        .a     (a_nib[idx_q]),
        .b     (b_nib[idx_q]),
        .c_in  (c_q),
        .s     (sum_nib),
        .c_out (c_out),
        .c3    ()
    );
`endif

    // Merge the freshly computed nibble into the running difference.
    always_comb begin
        d_d = d_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                d_d[i*NIBBLE_W +: NIBBLE_W] = sum_nib;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, step nibbles in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last_nib)  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are decoded from the state register only.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // Datapath: latch operands on accept, chain the carry through RUN and
    // capture the flags on the final nibble; everything holds in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            c_q      <= 1'b0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            if (state_q == ST_IDLE && in_valid) begin
                a_q   <= a;
                b_q   <= b;
                c_q   <= ~borrow_in;
                idx_q <= '0;
            end else if (state_q == ST_RUN) begin
                d_q <= d_d;
                c_q <= c_out;
                if (last_nib) begin
                    idx_q    <= '0;
                    borrow_q <= ~c_out;
                    zero_q   <= (d_d == '0);
`ifdef SUB_OVF_FLAG_EN
                    ovf_q    <= c3 ^ c_out;
`endif
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    assign d          = d_q;
    assign borrow_out = borrow_q;
    assign zero       = zero_q;
`ifdef SUB_OVF_FLAG_EN
    assign ovf        = ovf_q;
`endif

endmodule
